reg_file_arbiter: RTL and testbench
===================================

// Module: reg_file_arbiter
// PURPOSE
//   Shares the single register file (2 combinational read ports, 1 clocked write port) between two
//   requesters: req0 = CPU datapath, req1 = host/debug port. One transaction granted per cycle,
//   round-robin on conflict, optional lock so a requester can run atomic read-modify-write sequences.
//   Sits between the requesters and the register file; drives its reg_write/A_index/B_index/write_data.
// PARAMETERS
//   WIDTH     16  data width, matches register file
//   REG_BITS  4   register index width (16 registers, r0 reads as 0)
//   LOCK_MAX  15  idle cycles a lock owner may hold the file before forced release (>=1)
// PORTS
//   clk            in   1         clock, all state on rising edge
//   reset_n        in   1         asynchronous active-low reset
//   reqN_valid     in   1         (N=0,1) request present
//   reqN_ready     out  1         grant; transaction accepted when valid&ready
//   reqN_write     in   1         1 = write wdata to a_idx; reads of a_idx/b_idx always done
//   reqN_lock      in   1         keep ownership after this transaction
//   reqN_a_idx     in   REG_BITS  read index A / write index
//   reqN_b_idx     in   REG_BITS  read index B
//   reqN_wdata     in   WIDTH     write data
//   rspN_valid     out  1         one-cycle pulse, read data for requester N
//   rspN_a_data    out  WIDTH     value of a_idx sampled in grant cycle (pre-write)
//   rspN_b_data    out  WIDTH     value of b_idx sampled in grant cycle
//   lock_abort     out  1         one-cycle pulse: lock forcibly released by timeout
//   rf_reg_write   out  1         to register file write enable
//   rf_A_index     out  REG_BITS  to register file A index (also write index)
//   rf_B_index     out  REG_BITS  to register file B index
//   rf_write_data  out  WIDTH     to register file write data
//   rf_A_data      in   WIDTH     from register file
//   rf_B_data      in   WIDTH     from register file
// BEHAVIOUR
//   Reset (async, reset_n=0): state=IDLE, last_grant=1, idle_cnt=0, rspN_valid=0, rspN_*_data=0,
//     lock_abort=0; combinational outputs forced: readyN=0, rf_reg_write=0, rf indices/data=0.
//   States: IDLE (both eligible), LOCK0 (only req0 eligible), LOCK1 (only req1 eligible).
//   Arbitration (combinational, cycle T): eligible valid requesters compete; one valid -> it wins;
//     both valid in IDLE -> the one != last_grant wins. readyN=1 only for winner; ready may depend on
//     valid. Non-eligible requester's ready=0 regardless of owner activity.
//   Grant cycle T: rf_A_index/rf_B_index/rf_write_data = winner's a_idx/b_idx/wdata;
//     rf_reg_write = winner.write & (a_idx != 0) (writes to r0 suppressed, response still issued).
//     No grant: rf_reg_write=0, indices=0, write_data=0.
//   Posedge ending T: register file writes; rspW_a/b_data <= rf_A_data/rf_B_data (pre-write values);
//     rspW_valid=1 during T+1 only; last_grant <= W. Latency: 1 cycle, throughput 1 txn/cycle.
//   Response data registers hold value until next response for that requester.
//   Lock: granted txn with lock=1 -> next state LOCKW; granted txn by owner with lock=0 -> IDLE.
//     In LOCKW, idle_cnt increments each cycle owner has no grant, clears on grant; reaching LOCK_MAX
//     -> state IDLE, idle_cnt=0, lock_abort=1 for the following cycle. Entering IDLE clears idle_cnt.
//   Lock request by a requester in IDLE only honoured when it wins that cycle.
//   Reset mid-lock or mid-response: immediate return to reset values; a response due is dropped.
//   Back-to-back: write to rX at T then read rX at T+1 returns new value (file written at T edge).
// TESTING
//   1 Reset: hold reset_n=0 with both valid -> ready0/1=0, rf_reg_write=0, rsp*_valid=0.
//   2 Conflict: both valid 4 cycles, req0 write r3=16'h00AA, req1 read r3 -> grants 0,1,0,1;
//     first req1 response rsp1_a_data=16'h00AA one cycle after its grant.
//   3 Write r0: req0 write a_idx=0 wdata=16'hFFFF -> rf_reg_write=0, rsp0_valid pulses, read r0 = 0.
//   4 Pre-write read: r5=16'h1234, req1 write r5=16'h5678 -> rsp1_a_data=16'h1234, later read 16'h5678.
//   5 Lock: req0 lock=1 then 3 txns, req1 valid throughout -> ready1=0 until req0 txn with lock=0,
//     then req1 granted next cycle.
//   6 Timeout: req0 locks then idles LOCK_MAX=15 cycles -> lock_abort pulses once, req1 granted the
//     cycle after release; reset_n=0 during LOCK0 -> state IDLE, no lock_abort.

Source files
------------

// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter
// Shares one register file (two combinational read ports, one clocked write
// port) between the CPU datapath (req0) and the host/debug port (req1).
// The arbiter grants one transaction per cycle, uses round-robin on conflict,
// and supports a lock so the owner can run atomic read-modify-write sequences.
// A lock owner that stays idle for LOCK_MAX cycles loses the lock, and
// lock_abort reports the forced release.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | both requesters eligible, round-robin on conflict
// LOCK0 | req0 owns the file, req1 held off (ready1 = 0)
// LOCK1 | req1 owns the file, req0 held off (ready0 = 0)

module reg_file_arbiter #(
    parameter int WIDTH    = 16,
    parameter int REG_BITS = 4,
    parameter int LOCK_MAX = 15
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic                req0_write,
    input  logic                req0_lock,
    input  logic [REG_BITS-1:0] req0_a_idx,
    input  logic [REG_BITS-1:0] req0_b_idx,
    input  logic [WIDTH-1:0]    req0_wdata,

    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic                req1_write,
    input  logic                req1_lock,
    input  logic [REG_BITS-1:0] req1_a_idx,
    input  logic [REG_BITS-1:0] req1_b_idx,
    input  logic [WIDTH-1:0]    req1_wdata,

    output logic                rsp0_valid,
    output logic [WIDTH-1:0]    rsp0_a_data,
    output logic [WIDTH-1:0]    rsp0_b_data,
    output logic                rsp1_valid,
    output logic [WIDTH-1:0]    rsp1_a_data,
    output logic [WIDTH-1:0]    rsp1_b_data,

    output logic                lock_abort,

    output logic                rf_reg_write,
    output logic [REG_BITS-1:0] rf_A_index,
    output logic [REG_BITS-1:0] rf_B_index,
    output logic [WIDTH-1:0]    rf_write_data,
    input  logic [WIDTH-1:0]    rf_A_data,
    input  logic [WIDTH-1:0]    rf_B_data
);

    localparam int CNT_W = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic               lock_abort_q, lock_abort_d;
    logic               rsp0_valid_q, rsp0_valid_d;
    logic               rsp1_valid_q, rsp1_valid_d;
    logic [WIDTH-1:0]   rsp0_a_q, rsp0_a_d;
    logic [WIDTH-1:0]   rsp0_b_q, rsp0_b_d;
    logic [WIDTH-1:0]   rsp1_a_q, rsp1_a_d;
    logic [WIDTH-1:0]   rsp1_b_q, rsp1_b_d;

    logic               cand0, cand1;
    logic               grant0, grant1;

    // Arbitration: eligible valid requesters compete, the one that did not win
    // last time takes a conflict. Gating with reset_n keeps every grant low
    // while reset is asserted.
    always_comb begin
        cand0  = 1'b0;
        cand1  = 1'b0;
        grant0 = 1'b0;
        grant1 = 1'b0;
        cand0  = reset_n & req0_valid & (state_q != ST_LOCK1);
        cand1  = reset_n & req1_valid & (state_q != ST_LOCK0);
        grant0 = cand0 & (~cand1 | last_grant_q);
        grant1 = cand1 & (~cand0 | ~last_grant_q);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Steer the winner's fields onto the register file. Writes to r0 are
    // dropped here, but the response still goes out.
    always_comb begin
        rf_reg_write  = 1'b0;
        rf_A_index    = '0;
        rf_B_index    = '0;
        rf_write_data = '0;
        if (grant0) begin
            rf_reg_write  = req0_write & (req0_a_idx != '0);
            rf_A_index    = req0_a_idx;
            rf_B_index    = req0_b_idx;
            rf_write_data = req0_wdata;
        end else if (grant1) begin
            rf_reg_write  = req1_write & (req1_a_idx != '0);
            rf_A_index    = req1_a_idx;
            rf_B_index    = req1_b_idx;
            rf_write_data = req1_wdata;
        end
    end

    // Lock FSM and idle timer. The owner's idle count clears on every grant.
    // On reaching LOCK_MAX idle cycles the lock is dropped and the abort is
    // flagged for one cycle.
    always_comb begin
        state_d      = state_q;
        idle_cnt_d   = idle_cnt_q;
        lock_abort_d = 1'b0;
        last_grant_d = last_grant_q;
        if (grant0) begin
            last_grant_d = 1'b0;
        end else if (grant1) begin
            last_grant_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                idle_cnt_d = '0;
                if (grant0 && req0_lock) begin
                    state_d = ST_LOCK0;
                end else if (grant1 && req1_lock) begin
                    state_d = ST_LOCK1;
                end
            end
            ST_LOCK0: begin
                if (grant0) begin
                    idle_cnt_d = '0;
                    if (!req0_lock) begin
                        state_d = ST_IDLE;
                    end
                end else if (idle_cnt_q == CNT_LAST) begin
                    state_d      = ST_IDLE;
                    idle_cnt_d   = '0;
                    lock_abort_d = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end
            ST_LOCK1: begin
                if (grant1) begin
                    idle_cnt_d = '0;
                    if (!req1_lock) begin
                        state_d = ST_IDLE;
                    end
                end else if (idle_cnt_q == CNT_LAST) begin
                    state_d      = ST_IDLE;
                    idle_cnt_d   = '0;
                    lock_abort_d = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                idle_cnt_d = '0;
            end
        endcase
    end

    // Capture the pre-write read data of the granted transaction. Each
    // requester's data holds until that requester's next response.
    always_comb begin
        rsp0_valid_d = grant0;
        rsp1_valid_d = grant1;
        rsp0_a_d     = rsp0_a_q;
        rsp0_b_d     = rsp0_b_q;
        rsp1_a_d     = rsp1_a_q;
        rsp1_b_d     = rsp1_b_q;
        if (grant0) begin
            rsp0_a_d = rf_A_data;
            rsp0_b_d = rf_B_data;
        end
        if (grant1) begin
            rsp1_a_d = rf_A_data;
            rsp1_b_d = rf_B_data;
        end
    end

    // State register. Reset drops any pending response or lock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            idle_cnt_q   <= '0;
            lock_abort_q <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_a_q     <= '0;
            rsp0_b_q     <= '0;
            rsp1_a_q     <= '0;
            rsp1_b_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            idle_cnt_q   <= idle_cnt_d;
            lock_abort_q <= lock_abort_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_a_q     <= rsp0_a_d;
            rsp0_b_q     <= rsp0_b_d;
            rsp1_a_q     <= rsp1_a_d;
            rsp1_b_q     <= rsp1_b_d;
        end
    end

    assign rsp0_valid  = rsp0_valid_q;
    assign rsp0_a_data = rsp0_a_q;
    assign rsp0_b_data = rsp0_b_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp1_a_data = rsp1_a_q;
    assign rsp1_b_data = rsp1_b_q;
    assign lock_abort  = lock_abort_q;

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Testbench for reg_file_arbiter. The bench models the register file. Each
// granted transaction pushes its hand-computed read data into a per-requester
// queue, and a monitor compares that data and the latency whenever rspN_valid
// fires.

module tb_reg_file_arbiter;

    localparam int WIDTH    = 16;
    localparam int REG_BITS = 4;
    localparam int LOCK_MAX = 15;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                req0_valid, req0_ready, req0_write, req0_lock;
    logic [REG_BITS-1:0] req0_a_idx, req0_b_idx;
    logic [WIDTH-1:0]    req0_wdata;
    logic                req1_valid, req1_ready, req1_write, req1_lock;
    logic [REG_BITS-1:0] req1_a_idx, req1_b_idx;
    logic [WIDTH-1:0]    req1_wdata;
    logic                rsp0_valid, rsp1_valid;
    logic [WIDTH-1:0]    rsp0_a_data, rsp0_b_data, rsp1_a_data, rsp1_b_data;
    logic                lock_abort;
    logic                rf_reg_write;
    logic [REG_BITS-1:0] rf_A_index, rf_B_index;
    logic [WIDTH-1:0]    rf_write_data, rf_A_data, rf_B_data;

    typedef struct {
        int          cyc;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic exp_abort = 1'b0;

    logic [WIDTH-1:0] rf_mem [16];

    always #5 clk = ~clk;

    reg_file_arbiter #(.WIDTH(WIDTH), .REG_BITS(REG_BITS), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_lock(req0_lock), .req0_a_idx(req0_a_idx), .req0_b_idx(req0_b_idx),
        .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_lock(req1_lock), .req1_a_idx(req1_a_idx), .req1_b_idx(req1_b_idx),
        .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_a_data(rsp0_a_data), .rsp0_b_data(rsp0_b_data),
        .rsp1_valid(rsp1_valid), .rsp1_a_data(rsp1_a_data), .rsp1_b_data(rsp1_b_data),
        .lock_abort(lock_abort),
        .rf_reg_write(rf_reg_write), .rf_A_index(rf_A_index), .rf_B_index(rf_B_index),
        .rf_write_data(rf_write_data), .rf_A_data(rf_A_data), .rf_B_data(rf_B_data)
    );

    // Register file model: combinational reads, r0 hardwired to zero.
    assign rf_A_data = (rf_A_index == '0) ? '0 : rf_mem[rf_A_index];
    assign rf_B_data = (rf_B_index == '0) ? '0 : rf_mem[rf_B_index];

    always @(posedge clk) begin
        if (rf_reg_write && rf_A_index != '0) rf_mem[rf_A_index] <= rf_write_data;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (rsp0_valid) begin
                if (q0.size() == 0) begin
                    check("rsp0_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q0.pop_front();
                    check("rsp0_latency", cyc, e.cyc + 1);
                    check("rsp0_a_data", rsp0_a_data, e.a);
                    check("rsp0_b_data", rsp0_b_data, e.b);
                end
            end
            if (rsp1_valid) begin
                if (q1.size() == 0) begin
                    check("rsp1_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q1.pop_front();
                    check("rsp1_latency", cyc, e.cyc + 1);
                    check("rsp1_a_data", rsp1_a_data, e.a);
                    check("rsp1_b_data", rsp1_b_data, e.b);
                end
            end
        end
    end

    task automatic set0(input logic v, input logic w, input logic l,
                        input logic [3:0] a, input logic [3:0] b, input logic [15:0] d);
        req0_valid = v; req0_write = w; req0_lock = l;
        req0_a_idx = a; req0_b_idx = b; req0_wdata = d;
    endtask

    task automatic set1(input logic v, input logic w, input logic l,
                        input logic [3:0] a, input logic [3:0] b, input logic [15:0] d);
        req1_valid = v; req1_write = w; req1_lock = l;
        req1_a_idx = a; req1_b_idx = b; req1_wdata = d;
    endtask

    // One bus cycle: check grants against the expectation and queue the
    // expected read data for each granted requester.
    task automatic step(input logic er0, input logic er1,
                        input logic [15:0] e0a, input logic [15:0] e0b,
                        input logic [15:0] e1a, input logic [15:0] e1b);
        exp_t e;
        logic we;
        @(negedge clk);
        check("ready0", req0_ready, er0);
        check("ready1", req1_ready, er1);
        check("lock_abort", lock_abort, exp_abort);
        we = (er0 & req0_write & (req0_a_idx != 0)) | (er1 & req1_write & (req1_a_idx != 0));
        check("rf_reg_write", rf_reg_write, we);
        if (er0) begin
            check("rf_A_index0", rf_A_index, req0_a_idx);
            e.cyc = cyc; e.a = e0a; e.b = e0b;
            q0.push_back(e);
        end
        if (er1) begin
            check("rf_A_index1", rf_A_index, req1_a_idx);
            e.cyc = cyc; e.a = e1a; e.b = e1b;
            q1.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) rf_mem[i] = '0;
        reset_n = 1'b0;
        set0(1, 0, 0, 0, 0, 0);
        set1(1, 0, 0, 0, 0, 0);

        // Reset with both requesters asking
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready0", req0_ready, 1'b0);
        check("reset_ready1", req1_ready, 1'b0);
        check("reset_rf_reg_write", rf_reg_write, 1'b0);
        check("reset_rsp0_valid", rsp0_valid, 1'b0);
        check("reset_rsp1_valid", rsp1_valid, 1'b0);
        check("reset_lock_abort", lock_abort, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        set0(0, 0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Conflict: alternate grants starting with req0 (last_grant=1 after reset)
        set0(1, 1, 0, 3, 3, 16'h00AA);
        set1(1, 0, 0, 3, 3, 16'h0000);
        step(1, 0, 16'h0000, 16'h0000, 0, 0);
        step(0, 1, 0, 0, 16'h00AA, 16'h00AA);
        step(1, 0, 16'h00AA, 16'h00AA, 0, 0);
        step(0, 1, 0, 0, 16'h00AA, 16'h00AA);
        set0(0, 0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Write to r0 is suppressed, response still issued, r0 still reads 0
        set0(1, 1, 0, 0, 3, 16'hFFFF);
        step(1, 0, 16'h0000, 16'h00AA, 0, 0);
        set0(1, 0, 0, 0, 0, 16'h0000);
        step(1, 0, 16'h0000, 16'h0000, 0, 0);
        set0(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Pre-write read data, then back-to-back read of the new value
        set0(1, 1, 0, 5, 0, 16'h1234);
        step(1, 0, 16'h0000, 16'h0000, 0, 0);
        set0(0, 0, 0, 0, 0, 0);
        set1(1, 1, 0, 5, 5, 16'h5678);
        step(0, 1, 0, 0, 16'h1234, 16'h1234);
        set1(1, 0, 0, 5, 3, 16'h0000);
        step(0, 1, 0, 0, 16'h5678, 16'h00AA);
        set1(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Lock: req1 held off until req0 releases, then granted next cycle
        set1(1, 0, 0, 6, 5, 16'h0000);
        set0(1, 1, 1, 6, 0, 16'h0006);
        step(1, 0, 16'h0000, 16'h0000, 0, 0);
        set0(1, 1, 1, 6, 0, 16'h0016);
        step(1, 0, 16'h0006, 16'h0000, 0, 0);
        set0(1, 0, 1, 6, 5, 16'h0000);
        step(1, 0, 16'h0016, 16'h5678, 0, 0);
        set0(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        set0(1, 1, 0, 7, 6, 16'h0077);
        step(1, 0, 16'h0000, 16'h0016, 0, 0);
        set0(1, 0, 0, 7, 0, 16'h0000);
        step(0, 1, 0, 0, 16'h0016, 16'h5678);
        step(1, 0, 16'h0077, 16'h0000, 0, 0);
        set0(0, 0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Timeout: req0 locks and goes idle; abort after LOCK_MAX idle cycles
        set0(1, 0, 1, 7, 0, 16'h0000);
        step(1, 0, 16'h0077, 16'h0000, 0, 0);
        set0(0, 0, 0, 0, 0, 0);
        set1(1, 0, 0, 7, 6, 16'h0000);
        repeat (LOCK_MAX) step(0, 0, 0, 0, 0, 0);
        exp_abort = 1'b1;
        step(0, 1, 0, 0, 16'h0077, 16'h0016);
        exp_abort = 1'b0;
        set1(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Reset while in LOCK0: back to IDLE, no abort afterwards
        set0(1, 0, 1, 3, 0, 16'h0000);
        step(1, 0, 16'h00AA, 16'h0000, 0, 0);
        set0(0, 0, 0, 0, 0, 0);
        set1(1, 0, 0, 3, 0, 16'h0000);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        check("midlock_reset_ready1", req1_ready, 1'b0);
        check("midlock_reset_abort", lock_abort, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(0, 1, 0, 0, 16'h00AA, 16'h0000);
        step(0, 1, 0, 0, 16'h00AA, 16'h0000);
        set1(0, 0, 0, 0, 0, 0);
        repeat (LOCK_MAX + 2) step(0, 0, 0, 0, 0, 0);

        @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
